// File: rtl/tx8b10b_channel_arbiter_if.sv
// Bundles the requester byte streams and the transmitter FIFO write port
// shared by the channel arbiter and the logic around it.
interface tx8b10b_channel_arbiter_if #(
  parameter int NUM_CH = 4
);
  logic                  enable;
  logic [NUM_CH-1:0]     reqValid;
  logic [8*NUM_CH-1:0]   reqData;
  logic [NUM_CH-1:0]     reqLast;
  logic [NUM_CH-1:0]     reqReady;
  logic                  txFull;
  logic [7:0]            txDataIn;
  logic                  txWriteStrobe;
  logic                  grantValid;
  logic [3:0]            grantId;

  // Arbiter side
  modport master (
    input  enable, reqValid, reqData, reqLast, txFull,
    output reqReady, txDataIn, txWriteStrobe, grantValid, grantId
  );

  // Clients plus transmitter side
  modport slave (
    output enable, reqValid, reqData, reqLast, txFull,
    input  reqReady, txDataIn, txWriteStrobe, grantValid, grantId
  );
endinterface

// File: rtl/tx8b10b_channel_arbiter.sv
// Round-robin arbiter sharing one 8b10b transmitter FIFO write port between
// NUM_CH byte streams; each grant writes a channel-ID header then a capped burst.
module tx8b10b_channel_arbiter #(
  parameter int          NUM_CH    = 4,
  parameter int          MAX_BURST = 16,
  parameter logic [3:0]  HDR_TAG   = 4'hA
) (
  input  logic clk,
  input  logic rst,
  tx8b10b_channel_arbiter_if.master bus
);

  localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int CNT_W = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_BURST - 1);

  typedef enum logic [1:0] {IDLE, HEADER, DATA} state_t;

  state_t            state, stateNext;
  logic [CH_W-1:0]   grantPtr;
  logic [CH_W-1:0]   lastServed;
  logic [CH_W-1:0]   pickCh;
  logic [CNT_W-1:0]  burstCnt;
  logic              anyReq;
  logic              curValid;
  logic              curLast;
  logic [7:0]        curData;
  logic              xfer;
  logic              burstEnd;

  // First requesting channel after 'last', wrapping modulo NUM_CH.
  function automatic logic [CH_W-1:0] rrPick(input logic [NUM_CH-1:0] valid,
                                             input logic [CH_W-1:0]   last);
    logic [CH_W-1:0] sel;
    logic            found;
    int              idx;
    sel   = last;
    found = 1'b0;
    for (int k = 1; k <= NUM_CH; k++) begin
      idx = (int'(last) + k) % NUM_CH;
      if (!found && valid[CH_W'(idx)]) begin
        sel   = CH_W'(idx);
        found = 1'b1;
      end
    end
    return sel;
  endfunction

  assign anyReq   = |bus.reqValid;
  assign pickCh   = rrPick(bus.reqValid, lastServed);
  assign curValid = bus.reqValid[grantPtr];
  assign curLast  = bus.reqLast[grantPtr];
  assign curData  = bus.reqData[{grantPtr, 3'b000} +: 8];
  assign xfer     = (state == DATA) && curValid && !bus.txFull;
  assign burstEnd = curLast || (burstCnt == CNT_LAST);
  assign bus.grantId = 4'(grantPtr);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= stateNext;
  end

  always_comb begin
    stateNext         = state;
    bus.reqReady      = '0;
    bus.txWriteStrobe = 1'b0;
    bus.txDataIn      = 8'h00;
    bus.grantValid    = 1'b0;
    case (state)
      IDLE: begin
        if (bus.enable && anyReq) stateNext = HEADER;
      end
      HEADER: begin
        bus.grantValid = 1'b1;
        if (!bus.txFull) begin
          bus.txWriteStrobe = 1'b1;
          bus.txDataIn      = {HDR_TAG, 4'(grantPtr)};
          stateNext         = DATA;
        end
      end
      DATA: begin
        bus.grantValid = 1'b1;
        if (xfer) begin
          bus.reqReady[grantPtr] = 1'b1;
          bus.txWriteStrobe      = 1'b1;
          bus.txDataIn           = curData;
          if (burstEnd) stateNext = IDLE;
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  // Grant pointer, round-robin history and burst length tracking
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      grantPtr   <= '0;
      lastServed <= CH_W'(NUM_CH - 1);
      burstCnt   <= '0;
    end else begin
      if (state == IDLE && bus.enable && anyReq) grantPtr <= pickCh;
      if (state == HEADER && !bus.txFull)        burstCnt <= '0;
      else if (xfer)                             burstCnt <= burstCnt + CNT_W'(1);
      if (xfer && burstEnd)                      lastServed <= grantPtr;
    end
  end

endmodule

// File: tb/tb_tx8b10b_channel_arbiter.sv
// Scoreboard bench for tx8b10b_channel_arbiter: per-channel source queues feed
// the DUT, directed tests push expected FIFO bytes, a monitor pops and compares.
module tb_tx8b10b_channel_arbiter;
  localparam int NUM_CH    = 4;
  localparam int MAX_BURST = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;

  tx8b10b_channel_arbiter_if #(.NUM_CH(NUM_CH)) bus();

  tx8b10b_channel_arbiter #(
    .NUM_CH(NUM_CH), .MAX_BURST(MAX_BURST), .HDR_TAG(4'hA)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int wrCount  = 0;
  int wrCyc[$];
  logic [7:0] expQ[$];
  logic [8:0] chQ[NUM_CH][$];
  logic [NUM_CH-1:0] pend;
  logic [NUM_CH-1:0] otherRdy;
  logic [7:0] expByte;
  logic lastWrite = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  // Source driver: presents each channel queue head, pops on accepted handshake
  initial begin
    bus.reqValid = '0;
    bus.reqData  = '0;
    bus.reqLast  = '0;
    forever begin
      @(negedge clk);
      pend = bus.reqReady;
      @(posedge clk);
      #1;
      for (int c = 0; c < NUM_CH; c++) begin
        if (pend[c] && chQ[c].size() > 0) void'(chQ[c].pop_front());
        if (chQ[c].size() > 0) begin
          bus.reqValid[c]       = 1'b1;
          bus.reqData[8*c +: 8] = chQ[c][0][7:0];
          bus.reqLast[c]        = chQ[c][0][8];
        end else begin
          bus.reqValid[c]       = 1'b0;
          bus.reqData[8*c +: 8] = 8'h00;
          bus.reqLast[c]        = 1'b0;
        end
      end
    end
  end

  // Monitor: every FIFO write is checked against the scoreboard
  initial begin
    forever begin
      @(negedge clk);
      lastWrite = 1'b0;
      if (!rst) begin
        if (bus.txWriteStrobe) begin
          lastWrite = 1'b1;
          wrCount++;
          wrCyc.push_back(cyc);
          check("noWriteWhenFull", 32'(bus.txFull), 32'd0);
          otherRdy = bus.reqReady;
          otherRdy[bus.grantId[1:0]] = 1'b0;
          check("readyOnlyGranted", 32'(otherRdy), 32'd0);
          if (expQ.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpectedWrite actual=0x%0h required=no_write", bus.txDataIn);
          end else begin
            expByte = expQ.pop_front();
            check("txDataIn", 32'(bus.txDataIn), 32'(expByte));
          end
        end else begin
          check("dataZeroNoStrobe", 32'(bus.txDataIn), 32'd0);
          check("readyNoStrobe", 32'(bus.reqReady), 32'd0);
        end
      end
    end
  end

  task automatic waitWrites(input int target, input string name);
    int n = 0;
    while (wrCount < target && n < 200) begin
      @(negedge clk);
      #1;
      n++;
    end
    check({name, "_reached"}, 32'(wrCount >= target), 32'd1);
  endtask

  task automatic waitDrain(input string name);
    int n = 0;
    while ((expQ.size() != 0 || bus.grantValid) && n < 400) begin
      @(negedge clk);
      #1;
      n++;
    end
    check({name, "_drained"}, 32'(expQ.size()), 32'd0);
    repeat (2) @(posedge clk);
  endtask

  task automatic doReset();
    @(posedge clk);
    #2;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #3;
    rst = 1'b0;
  endtask

  initial begin
    int relCyc, s, d1, d2, bad, base, fifoCnt, fifoOverflow, n;
    bus.enable = 1'b1;
    bus.txFull = 1'b0;
    chQ[1].push_back({1'b1, 8'hE1});
    repeat (3) @(posedge clk);
    #3;
    check("rst_strobe", 32'(bus.txWriteStrobe), 32'd0);
    check("rst_ready", 32'(bus.reqReady), 32'd0);
    check("rst_data", 32'(bus.txDataIn), 32'd0);
    check("rst_grantValid", 32'(bus.grantValid), 32'd0);
    check("rst_grantId", 32'(bus.grantId), 32'd0);
    expQ.push_back(8'hA1); expQ.push_back(8'hE1);
    rst = 1'b0;
    relCyc = cyc;
    waitDrain("t0");
    check("t0_latency", 32'((wrCyc.size() == 2) ? wrCyc[0] - relCyc : -1), 32'd1);

    // Single channel, consecutive writes, then one dead IDLE cycle before next header
    s = wrCyc.size();
    chQ[2].push_back({1'b0, 8'h11}); chQ[2].push_back({1'b0, 8'h22});
    chQ[2].push_back({1'b1, 8'h33}); chQ[2].push_back({1'b1, 8'h44});
    expQ.push_back(8'hA2); expQ.push_back(8'h11); expQ.push_back(8'h22);
    expQ.push_back(8'h33); expQ.push_back(8'hA2); expQ.push_back(8'h44);
    waitDrain("t1");
    d1 = (wrCyc.size() >= s + 6) ? wrCyc[s+3] - wrCyc[s] : -1;
    d2 = (wrCyc.size() >= s + 6) ? wrCyc[s+4] - wrCyc[s+3] : -1;
    check("t1_consecutive", 32'(d1), 32'd3);
    check("t1_deadCycle", 32'(d2), 32'd2);

    // Round-robin with all channels requesting
    doReset();
    chQ[0].push_back({1'b1, 8'h50}); chQ[0].push_back({1'b1, 8'h51});
    chQ[1].push_back({1'b1, 8'h60});
    chQ[2].push_back({1'b1, 8'h70});
    chQ[3].push_back({1'b1, 8'h80});
    expQ.push_back(8'hA0); expQ.push_back(8'h50); expQ.push_back(8'hA1); expQ.push_back(8'h60);
    expQ.push_back(8'hA2); expQ.push_back(8'h70); expQ.push_back(8'hA3); expQ.push_back(8'h80);
    expQ.push_back(8'hA0); expQ.push_back(8'h51);
    waitDrain("t2");

    // Burst cap of 4 with ch0 interleaved between ch1 chunks
    doReset();
    for (int i = 0; i < 3; i++) chQ[0].push_back({1'b1, 8'(8'hC0 + i)});
    for (int i = 1; i <= 10; i++) chQ[1].push_back({(i == 10), 8'(i)});
    expQ.push_back(8'hA0); expQ.push_back(8'hC0);
    expQ.push_back(8'hA1); for (int i = 1; i <= 4; i++) expQ.push_back(8'(i));
    expQ.push_back(8'hA0); expQ.push_back(8'hC1);
    expQ.push_back(8'hA1); for (int i = 5; i <= 8; i++) expQ.push_back(8'(i));
    expQ.push_back(8'hA0); expQ.push_back(8'hC2);
    expQ.push_back(8'hA1); expQ.push_back(8'h09); expQ.push_back(8'h0A);
    waitDrain("t3");

    // Backpressure held in HEADER and again mid-DATA
    doReset();
    bus.txFull = 1'b1;
    base = wrCount;
    chQ[2].push_back({1'b0, 8'h91}); chQ[2].push_back({1'b0, 8'h92}); chQ[2].push_back({1'b1, 8'h93});
    expQ.push_back(8'hA2); expQ.push_back(8'h91); expQ.push_back(8'h92); expQ.push_back(8'h93);
    n = 0;
    while (!bus.grantValid && n < 20) begin
      @(posedge clk);
      #3;
      n++;
    end
    check("t4_granted", 32'(bus.grantValid), 32'd1);
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      if (bus.txWriteStrobe || bus.reqReady != 0) bad++;
      @(posedge clk);
      #3;
    end
    check("t4_holdHeader", 32'(bad), 32'd0);
    bus.txFull = 1'b0;
    waitWrites(base + 2, "t4_firstData");
    @(posedge clk);
    #1;
    bus.txFull = 1'b1;
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      #2;
      if (bus.txWriteStrobe || bus.reqReady != 0) bad++;
      @(posedge clk);
      #1;
    end
    check("t4_holdData", 32'(bad), 32'd0);
    bus.txFull = 1'b0;
    waitDrain("t4");

    // Depth-16 FIFO model with random draining drives txFull
    doReset();
    fifoCnt = 12;
    fifoOverflow = 0;
    for (int i = 1; i <= 5; i++) chQ[1].push_back({(i == 5), 8'(8'h20 + i)});
    chQ[3].push_back({1'b0, 8'h41}); chQ[3].push_back({1'b1, 8'h42});
    expQ.push_back(8'hA1); for (int i = 1; i <= 4; i++) expQ.push_back(8'(8'h20 + i));
    expQ.push_back(8'hA3); expQ.push_back(8'h41); expQ.push_back(8'h42);
    expQ.push_back(8'hA1); expQ.push_back(8'h25);
    n = 0;
    while ((expQ.size() != 0 || bus.grantValid) && n < 400) begin
      @(posedge clk);
      #1;
      if (lastWrite) fifoCnt++;
      if (fifoCnt > 16) fifoOverflow++;
      if (fifoCnt > 0 && $urandom_range(0, 3) == 0) fifoCnt--;
      bus.txFull = (fifoCnt >= 16);
      n++;
    end
    bus.txFull = 1'b0;
    check("t5_drained", 32'(expQ.size()), 32'd0);
    check("t5_noOverflow", 32'(fifoOverflow), 32'd0);
    repeat (2) @(posedge clk);

    // Asynchronous reset after the 2nd data byte of ch3
    doReset();
    base = wrCount;
    chQ[3].push_back({1'b0, 8'h31}); chQ[3].push_back({1'b0, 8'h32});
    chQ[3].push_back({1'b0, 8'h33}); chQ[3].push_back({1'b1, 8'h34});
    expQ.push_back(8'hA3); expQ.push_back(8'h31); expQ.push_back(8'h32);
    waitWrites(base + 3, "t6_secondData");
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("t6_asyncStrobe", 32'(bus.txWriteStrobe), 32'd0);
    check("t6_asyncReady", 32'(bus.reqReady), 32'd0);
    check("t6_asyncGrant", 32'(bus.grantValid), 32'd0);
    check("t6_asyncData", 32'(bus.txDataIn), 32'd0);
    chQ[3].delete();
    chQ[0].push_back({1'b1, 8'h01});
    chQ[3].push_back({1'b1, 8'h3A});
    expQ.push_back(8'hA0); expQ.push_back(8'h01); expQ.push_back(8'hA3); expQ.push_back(8'h3A);
    @(posedge clk);
    #3;
    rst = 1'b0;
    waitDrain("t6");

    // enable gating in IDLE, then dropped mid-burst
    doReset();
    bus.enable = 1'b0;
    chQ[1].push_back({1'b0, 8'hB1}); chQ[1].push_back({1'b1, 8'hB2});
    bad = 0;
    repeat (20) begin
      @(posedge clk);
      #3;
      if (bus.grantValid || bus.txWriteStrobe) bad++;
    end
    check("t7_noGrantDisabled", 32'(bad), 32'd0);
    base = wrCount;
    expQ.push_back(8'hA1); expQ.push_back(8'hB1); expQ.push_back(8'hB2);
    bus.enable = 1'b1;
    waitWrites(base + 1, "t7_header");
    @(posedge clk);
    #1;
    bus.enable = 1'b0;
    chQ[0].push_back({1'b1, 8'hD0});
    waitDrain("t7");
    repeat (10) @(posedge clk);
    #3;
    check("t7_noNewGrant", 32'(bus.grantValid), 32'd0);
    check("t7_ch0Pending", 32'(chQ[0].size()), 32'd1);
    check("t7_writeTotal", 32'(wrCount - base), 32'd3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "simulation watchdog expired");
  end

endmodule

// File: doc/tx8b10b_channel_arbiter.md
Name: tx8b10b_channel_arbiter

Overview:
Shares one 8b10b transmitter FIFO write port between NUM_CH byte-stream requesters. Arbitration is round-robin, one burst at a time. Each granted burst is a header byte carrying the channel ID, followed by up to MAX_BURST data bytes. The block sits between the client streams and the transmitter's dataIn/writeStrobe/full interface.

Parameters:
NUM_CH, 4, number of requesters; legal range 2..16.
MAX_BURST, 16, maximum data bytes per grant; legal range 1..256.
HDR_TAG, 4'hA, upper nibble of the header byte.

Ports:
clk  input  1  system clock.
rst  input  1  reset; asynchronous, active-high.
enable  input  1  allows new grants; sampled only in IDLE.
reqValid  input  NUM_CH  per-channel byte valid.
reqData  input  8*NUM_CH  per-channel byte; channel c occupies bits [8c+7:8c].
reqLast  input  NUM_CH  marks the final byte of a channel's message.
reqReady  output  NUM_CH  per-channel byte accepted this cycle.
txFull  input  1  transmitter FIFO full.
txDataIn  output  8  byte to the transmitter FIFO.
txWriteStrobe  output  1  write txDataIn into the FIFO this cycle.
grantValid  output  1  a burst is in progress (HEADER or DATA state).
grantId  output  4  channel currently granted; upper bits are zero when NUM_CH<16.

Behaviour:
- States: IDLE, HEADER, DATA. Registered state, grant pointer, last-served pointer, and burst counter (width clog2(MAX_BURST)).
- Reset values: state=IDLE, lastServed=NUM_CH-1 so channel 0 wins first, counter=0, grantId=0.
- Reset drives all outputs low: reqReady=0, txWriteStrobe=0, txDataIn=0, grantValid=0.
- Reset asserted mid-burst aborts immediately; no further header or data bytes are written.
- IDLE:
  - If enable=1 and any reqValid=1, pick the first channel with reqValid=1, searching from lastServed+1 with wrap-around modulo NUM_CH.
  - Register that channel as grantId and move to HEADER on the next edge.
  - Otherwise stay in IDLE.
- HEADER:
  - When txFull=0: txWriteStrobe=1 and txDataIn={HDR_TAG, grantId}; counter cleared; next state is DATA.
  - When txFull=1: hold with no strobe.
- DATA:
  - Transfer condition is reqValid[grantId]=1 and txFull=0.
  - On transfer: reqReady[grantId]=1, txWriteStrobe=1, txDataIn=reqData[grantId], counter increments.
  - The burst ends on a transfer with reqLast[grantId]=1, or on the transfer where counter==MAX_BURST-1.
  - At burst end: lastServed<=grantId, next state is IDLE.
  - A burst cut at MAX_BURST without reqLast resumes in a later grant, which starts with a new header.
  - If reqValid[grantId]=0, wait in DATA with no timeout; the grant is held.
  - reqReady for every other channel is always 0.
- reqReady and txWriteStrobe are combinational from state, reqValid and txFull. No byte is ever written while txFull=1. txFull is assumed to reflect all writes up to the previous cycle.
- txDataIn=0 whenever txWriteStrobe=0.
- grantValid=1 in HEADER and DATA.
- Latency: a request visible in IDLE produces its header write one cycle later, given txFull=0. Each burst has at least one dead cycle in IDLE between bursts.
- enable=0 during a burst has no effect; the burst completes and no new grant is issued afterwards.
- reqValid deasserting on a non-granted channel at any time is legal and has no effect.

Test Plan:
- Single channel: reset; ch2 sends 3 bytes 0x11,0x22,0x33 with reqLast on 0x33, txFull=0 → FIFO writes 0xA2,0x11,0x22,0x33 on consecutive cycles; grantValid falls after 0x33; one IDLE cycle follows.
- Round-robin: all 4 channels hold valid with 1-byte messages (reqLast=1) → header order 0xA0,0xA1,0xA2,0xA3,0xA0; no channel is granted twice before every other requesting channel has been served.
- Burst cap: MAX_BURST=4; ch1 streams 10 bytes with reqLast on the 10th → headers 0xA1 before bytes 1, 5 and 9; chunks of 4, 4, 2; ch0 requesting concurrently is interleaved between ch1 chunks.
- Backpressure: hold txFull=1 for 5 cycles in HEADER and again mid-DATA → txWriteStrobe=0 and reqReady=0 throughout; byte order is unchanged and no byte is lost or duplicated. Also drive a random txFull pattern against a FIFO model of depth 16 → no write ever occurs when full.
- Reset mid-burst: assert rst asynchronously after the 2nd data byte of ch3 → outputs are 0 immediately, without waiting for a clock edge; after release with ch0 and ch3 both requesting, ch0 is served first (header 0xA0).
- enable gating: enable=0 while ch1 is valid in IDLE → no grant for 20 cycles. Then deassert enable mid-burst → the burst finishes and no new header is written.
